// File: rtl/time_conversion_bcd_pkg.sv
// Shared constants and types for the nanosecond-to-BCD time display converter.
// Optional macro TIME_CONV_VALID_EN (see time_conversion_bcd.sv) does not affect this file.
package time_conv_pkg;

  localparam int NS_PER_TICK   = 100_000;   // one display tick = 100 us
  localparam int TICKS_PER_SEC = 10_000;
  localparam int TICKS_PER_MIN = 600_000;
  localparam int LATENCY       = 4;         // clocks from input to time_out, fixed
  localparam int MIN_CLAMP     = 99;        // largest minutes value the display can show

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/time_conversion_bcd_if.sv
// Data bus between the stopwatch counter (master) and the converter (slave).
// With TIME_CONV_VALID_EN defined, carries in_valid/out_valid qualifiers as well.
interface time_conversion_bcd_if #(
  parameter int IN_W = 39
);
  logic [IN_W-1:0] time_in;
  logic [31:0]     time_out;
`ifdef TIME_CONV_VALID_EN
  logic            in_valid;
  logic            out_valid;

  modport master (output time_in, output in_valid, input time_out, input out_valid);
  modport slave  (input time_in, input in_valid, output time_out, output out_valid);
`else
  modport master (output time_in, input time_out);
  modport slave  (input time_in, output time_out);
`endif
endinterface

// File: rtl/time_conversion_bcd_bin2bcd4.sv
// Combinational 14-bit binary (0..9999) to four BCD digits, shift-and-add-3.
module bin2bcd4
  import time_conv_pkg::*;
(
  input  logic [13:0]      bin_i,
  output bcd_t [3:0]       bcd_o   // [3] thousands .. [0] ones
);

  logic [29:0] sh;

  // Double-dabble: adjust every BCD column >= 5 before each left shift
  always_comb begin
    sh = {16'd0, bin_i};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[14+4*d +: 4] >= 4'd5) sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    bcd_o = sh[29:14];
  end

endmodule

// File: rtl/time_conversion_bcd.sv
// Elapsed-time (ns) to packed BCD display word MM SS mmm t, four-register pipeline.
// Optional macro TIME_CONV_VALID_EN: adds in_valid/out_valid; time_out then only
// updates on qualified samples and holds otherwise.
// Each constant division uses a floored reciprocal (quotient low by at most one)
// followed by a single remainder-compare correction, exact over the full input range.
// Intended for IN_W in roughly 36..48.
module time_conversion_bcd
  import time_conv_pkg::*;
#(
  parameter int IN_W = 39
) (
  input  logic                 clk,
  input  logic                 rst_n,
  time_conversion_bcd_if.slave bus
);

  localparam int T_W     = IN_W - 16;          // 100_000 > 2^16
  localparam int K1      = IN_W + 1;
  localparam int M1_W    = IN_W - 15;
  localparam int PROD1_W = IN_W + M1_W;
  localparam logic [M1_W-1:0] M1 = M1_W'((64'd1 << K1) / 64'(NS_PER_TICK));

  localparam int K2      = T_W + 1;
  localparam int M2_W    = T_W - 18;           // 600_000 > 2^19
  localparam int PROD2_W = T_W + M2_W;
  localparam int MIN_W   = PROD2_W - K2;
  localparam logic [M2_W-1:0] M2 = M2_W'((64'd1 << K2) / 64'(TICKS_PER_MIN));

  localparam int R_W     = 20;                 // remainder < 600_000
  localparam int K3      = 21;
  localparam logic [7:0] M3 = 8'((64'd1 << K3) / 64'(TICKS_PER_SEC));

  logic [IN_W-1:0]    x_q;
  logic [T_W-1:0]     t_q, t_d;
  logic [6:0]         min_q, min_d;
  logic [R_W-1:0]     r_q, r_d;
  logic [31:0]        time_out_q, time_out_d;

  logic [PROD1_W-1:0] prod1;
  logic [T_W-1:0]     q0;
  logic [IN_W-1:0]    rem1;

  logic [PROD2_W-1:0] prod2;
  logic [MIN_W-1:0]   m0, m1;
  logic [T_W-1:0]     rem2;
  logic [31:0]        min_ext;

  logic [27:0]        prod3;
  logic [6:0]         s0, sec_d;
  logic [R_W-1:0]     rem3;
  logic [13:0]        f_d;

  bcd_t [3:0]         f_bcd, sec_bcd, min_bcd;

  // S2: ticks of 100 us = floor(x / 100_000)
  always_comb begin
    prod1 = PROD1_W'(x_q) * PROD1_W'(M1);
    q0    = T_W'(prod1 >> K1);
    rem1  = x_q - IN_W'(q0) * IN_W'(NS_PER_TICK);
    t_d   = (rem1 >= IN_W'(NS_PER_TICK)) ? q0 + T_W'(1) : q0;
  end

  // S3: whole minutes and sub-minute remainder, saturating the display at 99:59.9999
  always_comb begin
    prod2 = PROD2_W'(t_q) * PROD2_W'(M2);
    m0    = MIN_W'(prod2 >> K2);
    rem2  = t_q - T_W'(m0) * T_W'(TICKS_PER_MIN);
    m1    = m0;
    r_d   = R_W'(rem2);
    if (rem2 >= T_W'(TICKS_PER_MIN)) begin
      m1  = m0 + MIN_W'(1);
      r_d = R_W'(rem2 - T_W'(TICKS_PER_MIN));
    end
    min_ext = 32'(m1);
    min_d   = min_ext[6:0];
    if (min_ext > 32'(MIN_CLAMP)) begin
      min_d = 7'(MIN_CLAMP);
      r_d   = R_W'(TICKS_PER_MIN - 1);
    end
  end

  // S4: seconds and sub-second ticks
  always_comb begin
    prod3 = 28'(r_q) * 28'(M3);
    s0    = 7'(prod3 >> K3);
    rem3  = r_q - R_W'(s0) * R_W'(TICKS_PER_SEC);
    sec_d = s0;
    f_d   = 14'(rem3);
    if (rem3 >= R_W'(TICKS_PER_SEC)) begin
      sec_d = s0 + 7'd1;
      f_d   = 14'(rem3 - R_W'(TICKS_PER_SEC));
    end
  end

  bin2bcd4 u_bcd_frac (.bin_i(f_d),             .bcd_o(f_bcd));
  bin2bcd4 u_bcd_sec  (.bin_i({7'd0, sec_d}),   .bcd_o(sec_bcd));
  bin2bcd4 u_bcd_min  (.bin_i({7'd0, min_q}),   .bcd_o(min_bcd));

  assign time_out_d = {min_bcd[1], min_bcd[0], sec_bcd[1], sec_bcd[0],
                       f_bcd[3], f_bcd[2], f_bcd[1], f_bcd[0]};

`ifdef TIME_CONV_VALID_EN
  logic [3:0] v_q;
  assign bus.out_valid = v_q[3];
`endif

  // Pipeline registers S1..S4; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      t_q        <= '0;
      min_q      <= '0;
      r_q        <= '0;
      time_out_q <= '0;
`ifdef TIME_CONV_VALID_EN
      v_q        <= '0;
`endif
    end else begin
      x_q   <= bus.time_in;
      t_q   <= t_d;
      min_q <= min_d;
      r_q   <= r_d;
`ifdef TIME_CONV_VALID_EN
      v_q   <= {v_q[2:0], bus.in_valid};
      if (v_q[2]) time_out_q <= time_out_d;
`else
      time_out_q <= time_out_d;
`endif
    end
  end

  assign bus.time_out = time_out_q;

endmodule

// File: tb/tb_time_conversion_bcd.sv
// Directed bench for time_conversion_bcd: reset, streaming cadence, rollovers,
// truncation, full-scale input, mid-stream reset and (if built with
// TIME_CONV_VALID_EN) the valid-qualified hold behaviour.
module tb_time_conversion_bcd;
  import time_conv_pkg::*;

  localparam int IN_W = 39;

  logic clk = 1'b0;
  logic rst_n;

  time_conversion_bcd_if #(.IN_W(IN_W)) bus ();

  time_conversion_bcd #(.IN_W(IN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected results in flight, indexed by clocks since the sample was driven
  logic [31:0] e_exp [1:4];
  logic        e_chk [1:4];
  string       e_tag [1:4];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic flush_model();
    for (int i = 1; i <= 4; i++) begin
      e_chk[i] = 1'b0;
      e_exp[i] = '0;
      e_tag[i] = "";
    end
  endtask

  // Drive one sample, clock once, and check the sample driven four clocks ago
  task automatic step(input logic [IN_W-1:0] tin, input logic [31:0] exp,
                      input bit chk, input string tag);
    bus.time_in = tin;
    @(posedge clk); #1;
    for (int i = 4; i > 1; i--) begin
      e_exp[i] = e_exp[i-1];
      e_chk[i] = e_chk[i-1];
      e_tag[i] = e_tag[i-1];
    end
    e_exp[1] = exp;
    e_chk[1] = chk;
    e_tag[1] = tag;
    if (e_chk[4]) check32(e_tag[4], bus.time_out, e_exp[4]);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.time_in = 39'd3_000_000_000;
`ifdef TIME_CONV_VALID_EN
    bus.in_valid = 1'b1;
`endif
    flush_model();

    // Held in reset: output stays clear regardless of input
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check32("reset_hold", bus.time_out, 32'h0000_0000);
    end

    // Release between edges; first result on the fourth edge
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check32("reset_latency", bus.time_out, 32'h0000_0000);
    end
    @(posedge clk); #1;
    check32("reset_first", bus.time_out, 32'h0003_0000);

    // Stream: +1 ms per clock, one result per clock
    for (int k = 0; k <= 10; k++) begin
      step(39'd3_000_000_000 + 39'(k) * 39'd1_000_000,
           (k < 10) ? (32'h0003_0000 | 32'(k << 4)) : 32'h0003_0100,
           1'b1, "stream");
    end

    // Directed vectors back to back
    step(39'd59_999_900_000,  32'h0059_9999, 1'b1, "sec_max");
    step(39'd60_000_000_000,  32'h0100_0000, 1'b1, "min_roll");
    step(39'd999_999,         32'h0000_0009, 1'b1, "trunc_999999");
    step(39'd99_999,          32'h0000_0000, 1'b1, "trunc_99999");
    step(39'd100_000,         32'h0000_0001, 1'b1, "one_tick");
    step(39'd549_755_813_887, 32'h0909_7558, 1'b1, "full_scale");
    step(39'd123_456_789_012, 32'h0203_4567, 1'b1, "mixed");
    step(39'd539_999_999_999, 32'h0859_9999, 1'b1, "min8_edge");
    step(39'd540_000_000_000, 32'h0900_0000, 1'b1, "min9");
    step(39'd9_999_999_999,   32'h0009_9999, 1'b1, "sec9_edge");
    step(39'd10_000_000_000,  32'h0010_0000, 1'b1, "sec10");
    step(39'd0,               32'h0000_0000, 1'b1, "zero");
    step(39'd61_234_500_000,  32'h0101_2345, 1'b1, "m1s1");
    for (int k = 0; k < 4; k++) step(39'd61_234_500_000, 32'h0101_2345, 1'b0, "drain");

    // Mid-stream reset: asynchronous clear, in-flight samples discarded
    #2 rst_n = 1'b0;
    #1 check32("async_clear", bus.time_out, 32'h0000_0000);
    flush_model();
    bus.time_in = 39'd999_999;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check32("midrst_discard", bus.time_out, 32'h0000_0000);
    end
    @(posedge clk); #1;
    check32("midrst_first", bus.time_out, 32'h0000_0009);

`ifdef TIME_CONV_VALID_EN
    // Qualified output: hold while invalid, single pulse passes with 4-clock latency
    bus.in_valid = 1'b0;
    bus.time_in  = 39'd3_000_000_000;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check32("v_idle_valid", 32'(bus.out_valid), 32'd0);
      check32("v_idle_hold", bus.time_out, 32'h0000_0009);
    end
    bus.in_valid = 1'b1;
    bus.time_in  = 39'd61_234_500_000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.time_in  = 39'd3_000_000_000;
    check32("v_pulse_lat1", 32'(bus.out_valid), 32'd0);
    for (int k = 2; k <= 3; k++) begin
      @(posedge clk); #1;
      check32("v_pulse_lat", 32'(bus.out_valid), 32'd0);
      check32("v_pulse_hold", bus.time_out, 32'h0000_0009);
    end
    @(posedge clk); #1;
    check32("v_pulse_valid", 32'(bus.out_valid), 32'd1);
    check32("v_pulse_data", bus.time_out, 32'h0101_2345);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check32("v_after_valid", 32'(bus.out_valid), 32'd0);
      check32("v_after_hold", bus.time_out, 32'h0101_2345);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_conversion_bcd.md
Name: time_conversion_bcd

Overview:
- Converts a free-running elapsed-time count in nanoseconds into a packed 8-digit BCD display word, MM SS mmm t (minutes, seconds, milliseconds, 100 µs).
- Sits between the stopwatch/timer counter and the 7-segment display driver.
- Fully pipelined: accepts a new sample every clock and produces a result a fixed latency later.

Parameters:
- IN_W, 39, width of the nanosecond input (2^39 ns ≈ 549.76 s).
- LATENCY, 4, clocks from input sample edge to registered output. Fixed; documentation only, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- time_in  input  IN_W  elapsed time, unsigned, units of 1 ns
- time_out  output  32  packed BCD, digit layout below

Behaviour:
- Digit layout of time_out:
  - [31:28] minutes tens
  - [27:24] minutes ones
  - [23:20] seconds tens (0-5)
  - [19:16] seconds ones
  - [15:12] ms hundreds
  - [11:8] ms tens
  - [7:4] ms ones
  - [3:0] 100 µs digit
- Arithmetic, all unsigned and truncating (never rounding):
  - t = floor(time_in / 100_000), in 100 µs units; max 5_497_558, 23 bits.
  - min = t / 600_000.
  - r = t % 600_000.
  - sec = r / 10_000.
  - f = r % 10_000, giving four BCD digits.
- Range: minutes never exceed 9 for IN_W=39, so the tens digit is always 0. It is still computed generically, clamped at 99 minutes.
- Pipeline, one stage per clock:
  - S1: register time_in.
  - S2: divide by 100_000.
  - S3: split into minutes and remainder.
  - S4: split into seconds and sub-second, binary-to-BCD, register time_out.
- Constant division is implemented as multiply-by-reciprocal with a correction step. Results must be exact for every input 0..2^IN_W-1.
- Throughput: one result per clock. time_out at edge n+4 reflects time_in sampled at edge n.
- Input may change every cycle; there is no handshake.
- Reset: all pipeline registers and time_out clear to 0 asynchronously while rst_n=0.
  - The first valid result appears 4 clocks after the first edge with rst_n=1.
  - Reset asserted mid-stream discards in-flight samples.
- Every BCD nibble is always in 0-9; seconds tens is in 0-5.

Optional Feature:
- Macro: TIME_CONV_VALID_EN.
- Defined:
  - Adds input in_valid (1 bit) and output out_valid (1 bit).
  - in_valid is delayed through a 4-stage shift register aligned with the data, reset to 0.
  - time_out updates only when the delayed valid is 1 and holds otherwise.
- Undefined: ports absent; time_out updates every clock.

Decomposition:
- Shared package time_conv_pkg holds:
  - NS_PER_TICK = 100_000
  - TICKS_PER_SEC = 10_000
  - TICKS_PER_MIN = 600_000
  - LATENCY = 4
  - a typedef for the 4-bit BCD digit
- One sub-module, bin2bcd4: combinational 14-bit binary (0..9999) to four BCD digits (double-dabble). It is instantiated for the sub-second field.
- The 2-digit minutes and seconds fields reuse it with the upper digits ignored.

Test Plan:
- Reset: hold rst_n=0, drive time_in=3_000_000_000 -> time_out stays 32'h0000_0000; after release, 32'h0003_0000 appears exactly 4 clocks later.
- Stream: start at 3_000_000_000, add 1_000_000 every clock -> consecutive outputs 32'h0003_0000, 32'h0003_0010, 32'h0003_0020 … with one-per-clock cadence and 4-cycle latency; at 3_010_000_000 expect 32'h0003_0100.
- Second rollover: 59_999_900_000 -> 32'h0059_9999; then 60_000_000_000 -> 32'h0100_0000.
- Truncation: 999_999 -> 32'h0000_0009; 99_999 -> 32'h0000_0000.
- Maximum: 2^39-1 (549_755_813_887) -> 32'h0909_7558.
- With TIME_CONV_VALID_EN: pulse in_valid on one cycle with 61_234_500_000 -> out_valid high exactly 4 clocks later with 32'h0101_2345; time_out holds on other cycles.
